// File: rtl/fp_add_arb_pkg.sv
// Shared types and constants for the arbitrated single-precision add/sub pipeline.
package fp_add_arb_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ID_MAX_W   = 3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic                  symbol;
        logic [ID_MAX_W-1:0]   id;
    } s1_entry_t;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] out;
        logic [ID_MAX_W-1:0]   id;
    } s2_entry_t;

endpackage

// File: rtl/fp_addsub.sv
// Combinational single-precision add/sub, round-to-nearest-even.
// Denormal inputs and underflowing results flush to zero; overflow saturates to infinity.
module fp_addsub (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        symbol,
    output logic [31:0] out
);
    import fp_add_arb_pkg::*;

    logic              sign_a, sign_b, sign_r, swap, sticky, inc;
    logic [7:0]        exp_a, exp_b, exp_big, exp_diff;
    logic [23:0]       man_a, man_b, man_big, man_small;
    logic [26:0]       ext_big, ext_small, shifted, norm;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic signed [9:0] exp_r;
    logic [24:0]       rounded;

    always_comb begin
        sign_a    = a[31];
        sign_b    = b[31] ^ (symbol == OP_SUB);
        exp_a     = a[30:23];
        exp_b     = b[30:23];
        man_a     = (exp_a != 8'd0) ? {1'b1, a[22:0]} : 24'd0;
        man_b     = (exp_b != 8'd0) ? {1'b1, b[22:0]} : 24'd0;
        swap      = {exp_b, man_b} > {exp_a, man_a};
        exp_big   = swap ? exp_b : exp_a;
        exp_diff  = swap ? exp_b - exp_a : exp_a - exp_b;
        man_big   = swap ? man_b : man_a;
        man_small = swap ? man_a : man_b;
        sign_r    = swap ? sign_b : sign_a;
        ext_big   = {man_big, 3'b000};
        ext_small = {man_small, 3'b000};

        // Bits shifted past the round position collapse into the sticky bit.
        if (exp_diff > 8'd26) begin
            shifted = '0;
            sticky  = |man_small;
        end else begin
            shifted = ext_small >> exp_diff;
            sticky  = |(ext_small & ~(27'h7FF_FFFF << exp_diff));
        end
        shifted[0] = shifted[0] | sticky;

        if (sign_a == sign_b) sum = {1'b0, ext_big} + {1'b0, shifted};
        else                  sum = {1'b0, ext_big} - {1'b0, shifted};

        lz = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end

        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_r = $signed({2'b00, exp_big}) + 10'sd1;
        end else begin
            norm  = sum[26:0] << lz;
            exp_r = $signed({2'b00, exp_big}) - $signed({5'b00000, lz});
        end

        inc     = norm[2] & (norm[1] | norm[0] | norm[3]);
        rounded = {1'b0, norm[26:3]} + {24'd0, inc};
        if (rounded[24]) begin
            rounded = rounded >> 1;
            exp_r   = exp_r + 10'sd1;
        end

        if (sum == 28'd0 || exp_r <= 0) out = 32'd0;
        else if (exp_r >= 255)          out = {sign_r, 8'hFF, 23'd0};
        else                            out = {sign_r, exp_r[7:0], rounded[22:0]};
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first asserted request at or after ptr.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    always_comb begin
        grant = '0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (grant == '0 && req[idx]) grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin shared FP add/sub: operand stage S1, shared adder, result stage S2.
module fp_add_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]            req_symbol,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [DATA_WIDTH-1:0]         resp_out,
    output logic [ID_W-1:0]               resp_id,
    output logic                          busy,
    output logic [15:0]                   op_count
);
    import fp_add_arb_pkg::*;

    localparam int PW = $clog2(NUM_REQ);

    s1_entry_t          s1;
    s2_entry_t          s2;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic [31:0]        alu_out;
    logic               s2_load, s1_load, accept;
    logic               unused_id;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    fp_addsub u_alu (
        .a      (s1.a),
        .b      (s1.b),
        .symbol (s1.symbol),
        .out    (alu_out)
    );

    // Grant is offered only when S1 can take it, so a held request is never dropped.
    always_comb begin
        s2_load   = !s2.valid || resp_ready;
        s1_load   = !s1.valid || s2_load;
        req_ready = (s1_load && !rst) ? grant : '0;
        accept    = |(req_valid & req_ready);
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_idx = PW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1.valid <= 1'b0;
            s2.valid <= 1'b0;
            s2.out   <= '0;
            s2.id    <= '0;
            rr_ptr   <= '0;
            op_count <= '0;
        end else begin
            if (s2.valid && resp_ready) op_count <= op_count + 16'd1;
            if (s2_load) begin
                s2.valid <= s1.valid;
                if (s1.valid) begin
                    s2.out <= alu_out;
                    s2.id  <= s1.id;
                end
            end
            if (s1_load) begin
                s1.valid <= accept;
                if (accept) begin
                    s1.a      <= req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                    s1.b      <= req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                    s1.symbol <= req_symbol[grant_idx];
                    s1.id     <= ID_MAX_W'(grant_idx);
                    rr_ptr    <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
        end
    end

    assign resp_valid = s2.valid;
    assign resp_out   = s2.out;
    assign resp_id    = s2.id[ID_W-1:0];
    assign busy       = s1.valid | s2.valid;
    assign unused_id  = ^s2.id;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: latency, arbitration order, backpressure, reset, counter wrap.
module tb_fp_add_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    localparam logic [31:0] F1 = 32'h3F80_0000;
    localparam logic [31:0] F2 = 32'h4000_0000;
    localparam logic [31:0] F3 = 32'h4040_0000;
    localparam logic [31:0] F4 = 32'h4080_0000;
    localparam logic [31:0] F5 = 32'h40A0_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N-1:0]    req_symbol;
    logic            resp_valid;
    logic            resp_ready;
    logic [DW-1:0]   resp_out;
    logic [1:0]      resp_id;
    logic            busy;
    logic [15:0]     op_count;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_grant, n_resp;
    logic        auto_drop, log_en;
    int          grant_q[$];
    int          rid_q[$];
    logic [31:0] rout_q[$];
    int          exp_ids[$];
    logic [31:0] exp_outs[$];

    fp_add_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_symbol (req_symbol),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_out   (resp_out),
        .resp_id    (resp_id),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Requester i: a = (i+1).0, b = 1.0, add -> result (i+2).0
    task automatic set_default_ops();
        logic [31:0] fv [0:3];
        fv = '{F1, F2, F3, F4};
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW] = fv[i];
            req_b[i*DW +: DW] = F1;
        end
        req_symbol = '0;
    endtask

    task automatic clear_logs();
        grant_q.delete();
        rid_q.delete();
        rout_q.delete();
        exp_ids.delete();
        exp_outs.delete();
    endtask

    task automatic expect_resp(input int id, input logic [31:0] o);
        exp_ids.push_back(id);
        exp_outs.push_back(o);
    endtask

    // One clock: observe handshakes mid-cycle, then withdraw accepted requests after the edge.
    task automatic run_cycle();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        if ($countones(req_ready) > 1) chk("ready_onehot", $countones(req_ready), 1);
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                grant_q.push_back(i);
                n_grant++;
            end
        end
        if (resp_valid && resp_ready) begin
            n_resp++;
            if (log_en) begin
                rid_q.push_back(int'(resp_id));
                rout_q.push_back(resp_out);
            end
        end
        @(posedge clk);
        #1;
        if (auto_drop) req_valid = req_valid & ~hs;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((busy || req_valid != '0) && t < 200) begin
            run_cycle();
            t++;
        end
        if (t >= 200) chk("drain_timeout", 1, 0);
    endtask

    task automatic check_logs(input string tag);
        chk($sformatf("%s_ngrant", tag), grant_q.size(), exp_ids.size());
        chk($sformatf("%s_nresp", tag), rid_q.size(), exp_ids.size());
        foreach (exp_ids[i]) begin
            if (i < grant_q.size()) chk($sformatf("%s_grant%0d", tag, i), grant_q[i], exp_ids[i]);
            if (i < rid_q.size()) begin
                chk($sformatf("%s_id%0d", tag, i), rid_q[i], exp_ids[i]);
                chk($sformatf("%s_out%0d", tag, i), rout_q[i], exp_outs[i]);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        req_valid  = '1;
        resp_ready = 1'b1;
        auto_drop  = 1'b1;
        log_en     = 1'b1;
        n_grant    = 0;
        n_resp     = 0;
        set_default_ops();

        // Reset state
        step();
        step();
        chk("rst_ready", req_ready, 0);
        req_valid = '0;
        rst       = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_resp_out", resp_out, 0);
        chk("rst_resp_id", resp_id, 0);

        // Single request from requester 0: 1.0 + 2.0, result two cycles after acceptance
        req_a[0 +: DW] = F1;
        req_b[0 +: DW] = F2;
        req_valid      = 4'b0001;
        #1;
        chk("lat_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        chk("lat_c1_valid", resp_valid, 0);
        chk("lat_c1_busy", busy, 1);
        step();
        chk("lat_c2_valid", resp_valid, 1);
        chk("lat_c2_out", resp_out, F3);
        chk("lat_c2_id", resp_id, 0);
        step();
        chk("lat_c3_valid", resp_valid, 0);
        chk("lat_c3_count", op_count, 1);
        chk("lat_c3_busy", busy, 0);

        // Requester 2 subtracts: 3.0 - 1.0, then 5.0 - 5.0
        clear_logs();
        req_a[2*DW +: DW] = F3;
        req_b[2*DW +: DW] = F1;
        req_symbol[2]     = 1'b1;
        req_valid[2]      = 1'b1;
        drain();
        req_a[2*DW +: DW] = F5;
        req_b[2*DW +: DW] = F5;
        req_valid[2]      = 1'b1;
        drain();
        expect_resp(2, F2);
        expect_resp(2, 32'h0000_0000);
        check_logs("sub");
        set_default_ops();

        // All four requesters held valid for 8 cycles
        do_reset();
        clear_logs();
        auto_drop = 1'b0;
        req_valid = '1;
        repeat (8) run_cycle();
        req_valid = '0;
        auto_drop = 1'b1;
        drain();
        for (int r = 0; r < 2; r++) begin
            expect_resp(0, F2);
            expect_resp(1, F3);
            expect_resp(2, F4);
            expect_resp(3, F5);
        end
        check_logs("rr");

        // Backpressure: resp_ready low for 5 cycles with 3 requesters active
        do_reset();
        clear_logs();
        resp_ready = 1'b0;
        req_valid  = 4'b0111;
        for (int k = 0; k < 5; k++) begin
            run_cycle();
            if (k >= 1) begin
                chk($sformatf("bp_ready%0d", k), req_ready, 0);
                chk($sformatf("bp_valid%0d", k), resp_valid, 1);
                chk($sformatf("bp_out%0d", k), resp_out, F2);
            end
        end
        chk("bp_held", grant_q.size(), 2);
        chk("bp_busy", busy, 1);
        resp_ready = 1'b1;
        drain();
        expect_resp(0, F2);
        expect_resp(1, F3);
        expect_resp(2, F4);
        check_logs("bp");
        chk("bp_count", op_count, 3);

        // Reset with both stages full; pending requesters re-served from index 0
        clear_logs();
        resp_ready = 1'b0;
        req_valid  = 4'b1010;
        run_cycle();
        run_cycle();
        chk("mr_ngrant", grant_q.size(), 2);
        if (grant_q.size() == 2) begin
            chk("mr_grant0", grant_q[0], 3);
            chk("mr_grant1", grant_q[1], 1);
        end
        chk("mr_full_busy", busy, 1);
        chk("mr_full_id", resp_id, 3);
        chk("mr_pre_count", op_count, 3);
        req_valid = 4'b0101;
        run_cycle();
        rst = 1'b1;
        #1;
        chk("mr_rst_ready", req_ready, 0);
        step();
        rst = 1'b0;
        chk("mr_busy", busy, 0);
        chk("mr_resp_valid", resp_valid, 0);
        chk("mr_count", op_count, 0);
        clear_logs();
        resp_ready = 1'b1;
        drain();
        expect_resp(0, F2);
        expect_resp(2, F4);
        check_logs("mr");

        // 65537 results wrap op_count to 1
        do_reset();
        resp_ready = 1'b1;
        auto_drop  = 1'b0;
        log_en     = 1'b0;
        n_grant    = 0;
        n_resp     = 0;
        req_valid  = 4'b0001;
        for (int t = 0; t < 70000 && n_grant < 65537; t++) run_cycle();
        if (n_grant < 65537) chk("wrap_timeout", n_grant, 65537);
        req_valid = '0;
        auto_drop = 1'b1;
        drain();
        chk("wrap_nresp", n_resp, 65537);
        chk("wrap_count", op_count, 16'h0001);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
